// File: rtl/crf_seq_pkg.sv
// crf_seq_pkg: FSM encoding, error codes and default register map for crf_frame_sequencer
package crf_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_START  = 4'd1,
    S_B_START   = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_RD_ADDR   = 4'd4,
    S_RD_DATA   = 4'd5,
    S_WR_END    = 4'd6,
    S_B_END     = 4'd7,
    S_NEXT      = 4'd8
  } seq_state_e;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_CNT  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
  localparam logic [31:0] DEF_UPSTART_ADDR    = 32'h0000_0000;
  localparam logic [31:0] DEF_UPEND_ADDR      = 32'h0000_0004;
  localparam logic [31:0] DEF_UPINHSKCNT_ADDR = 32'h0000_0008;
  localparam int DEF_EXP_INHSKCNT = 129600;
endpackage

// File: rtl/crf_frame_sequencer_axil_wr_channel.sv
// axil_wr_channel: AW/W valid-hold with per-channel done flags for one AXI4-Lite register write
module axil_wr_channel #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  input  logic              wready,
  output logic              done
);
  logic aw_done, w_done;
  assign done = aw_done & w_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (go) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= addr;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
    end
endmodule

// File: rtl/crf_frame_sequencer.sv
// crf_frame_sequencer: AXI4-Lite master running UPSTART/UPINHSKCNT/UPEND per frame; SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog
module crf_frame_sequencer
  import crf_seq_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] UPSTART_ADDR    = AXI_ADDR_WIDTH'(DEF_UPSTART_ADDR),
  parameter logic [AXI_ADDR_WIDTH-1:0] UPEND_ADDR      = AXI_ADDR_WIDTH'(DEF_UPEND_ADDR),
  parameter logic [AXI_ADDR_WIDTH-1:0] UPINHSKCNT_ADDR = AXI_ADDR_WIDTH'(DEF_UPINHSKCNT_ADDR),
  parameter logic [AXI_DATA_WIDTH-1:0] EXP_INHSKCNT    = AXI_DATA_WIDTH'(DEF_EXP_INHSKCNT),
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 n_frames,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        all_done,
  output logic [15:0]                 frame_cnt,
  output logic                        err,
  output logic [1:0]                  err_code,
  input  logic                        interrupt_updone,
  output logic                        m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  input  logic                        m_axi_awready,
  output logic                        m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready,
  output logic                        m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        m_axi_rready
);
  seq_state_e state, nxt;
  logic [15:0] n_lat;
  logic wr_go, wr_done, set_err, last, tmo;
  logic [1:0] code;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;
  assign m_axi_wdata  = AXI_DATA_WIDTH'(1);
  assign last    = frame_cnt + 16'd1 == n_lat;
  assign wr_addr = state == S_RD_DATA ? UPEND_ADDR : UPSTART_ADDR;
`ifdef SEQ_TIMEOUT_EN
  logic [24:0] wd;
  always_ff @(posedge clk or posedge rst)
    if (rst) wd <= '0;
    else wd <= state == S_WAIT_DONE ? wd + 25'd1 : '0;
  assign tmo = state == S_WAIT_DONE && wd == 25'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif
  axil_wr_channel #(.ADDR_W(AXI_ADDR_WIDTH)) u_wr (
    .clk(clk), .rst(rst), .go(wr_go), .addr(wr_addr),
    .awvalid(m_axi_awvalid), .awaddr(m_axi_awaddr), .awready(m_axi_awready),
    .wvalid(m_axi_wvalid), .wready(m_axi_wready), .done(wr_done)
  );
  always_comb begin
    nxt = state;
    wr_go = 1'b0;
    set_err = 1'b0;
    code = ERR_NONE;
    case (state)
      S_IDLE: if (start && n_frames != 16'd0) begin
        nxt = S_WR_START;
        wr_go = 1'b1;
      end
      S_WR_START: if (wr_done) nxt = S_B_START;
      S_WR_END: if (wr_done) nxt = S_B_END;
      S_B_START, S_B_END: if (m_axi_bvalid) begin
        set_err = m_axi_bresp != 2'b00;
        code = ERR_RESP;
        nxt = set_err ? S_IDLE : state == S_B_START ? S_WAIT_DONE : S_NEXT;
      end
      S_WAIT_DONE: if (interrupt_updone) nxt = S_RD_ADDR;
        else if (tmo) begin
          set_err = 1'b1;
          code = ERR_TMO;
          nxt = S_IDLE;
        end
      S_RD_ADDR: if (m_axi_arready) nxt = S_RD_DATA;
      S_RD_DATA: if (m_axi_rvalid) begin
        set_err = m_axi_rresp != 2'b00 || m_axi_rdata != EXP_INHSKCNT;
        code = m_axi_rresp != 2'b00 ? ERR_RESP : ERR_CNT;
        nxt = set_err ? S_IDLE : S_WR_END;
        wr_go = !set_err;
      end
      S_NEXT: begin
        nxt = last ? S_IDLE : S_WR_START;
        wr_go = !last;
      end
      default: nxt = S_IDLE;
    endcase
  end
  // Handshake outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      n_lat <= '0;
      frame_cnt <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      all_done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_rready <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != S_IDLE;
      m_axi_bready <= nxt == S_B_START || nxt == S_B_END;
      m_axi_arvalid <= nxt == S_RD_ADDR;
      m_axi_rready <= nxt == S_RD_DATA;
      frame_done <= state == S_NEXT;
      all_done <= (state == S_NEXT && last) || (state == S_IDLE && start && n_frames == 16'd0);
      if (nxt == S_RD_ADDR) m_axi_araddr <= UPINHSKCNT_ADDR;
      if (state == S_IDLE && start) begin
        n_lat <= n_frames;
        frame_cnt <= '0;
        err <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (state == S_NEXT) frame_cnt <= frame_cnt + 16'd1;
      if (set_err) begin
        err <= 1'b1;
        err_code <= code;
      end
    end
endmodule

// File: tb/tb_crf_frame_sequencer.sv
// tb_crf_frame_sequencer: table-driven batches against an AXI4-Lite register responder model
module tb_crf_frame_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, interrupt_updone;
  logic [15:0] n_frames = 16'd0;
  logic busy, frame_done, all_done, err;
  logic [15:0] frame_cnt;
  logic [1:0] err_code;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic [3:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  crf_frame_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .n_frames(n_frames), .busy(busy),
    .frame_done(frame_done), .all_done(all_done), .frame_cnt(frame_cnt), .err(err),
    .err_code(err_code), .interrupt_updone(interrupt_updone),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rready(m_axi_rready)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // responder configuration and observation
  int aw_dly = 0, w_dly = 0, ar_dly = 0, bad_b = -1;
  logic [31:0] rd_val = 32'd129600;
  logic int_never = 1'b0;
  int fd_cnt = 0, ad_cnt = 0;
  logic [32:0] op_log[$];
  int aw_wait, w_wait, ar_wait, wr_idx, int_cnt;
  logic aw_got, w_got, ar_got, b_fire, r_fire, b_start, pa, pw, pr;
  logic [31:0] last_aw, pa_addr, pr_addr;
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
      m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0; interrupt_updone = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; wr_idx = 0; int_cnt = -1;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; b_start = 0;
      pa = 0; pw = 0; pr = 0; last_aw = 0; pa_addr = 0; pr_addr = 0;
    end else begin
      fd_cnt += int'(frame_done);
      ad_cnt += int'(all_done);
      if (pa) chk("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, pa_addr}));
      if (pw) chk("w_hold", 64'({m_axi_wvalid, m_axi_wdata}), 64'({1'b1, 32'd1}));
      if (pr) chk("ar_hold", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, pr_addr}));
      if (int_cnt > 0) int_cnt--;
      else if (int_cnt == 0) begin
        interrupt_updone = 1;
        int_cnt = -1;
      end
      if (b_fire) begin
        m_axi_bvalid = 0;
        if (b_start && m_axi_bresp == 2'b00 && !int_never) int_cnt = 20;
      end else if (!m_axi_bvalid && aw_got && w_got) begin
        m_axi_bvalid = 1;
        m_axi_bresp = wr_idx == bad_b ? 2'b10 : 2'b00;
        b_start = last_aw == 32'h0;
        wr_idx++;
        aw_got = 0;
        w_got = 0;
      end
      b_fire = m_axi_bvalid && m_axi_bready;
      if (r_fire) m_axi_rvalid = 0;
      else if (!m_axi_rvalid && ar_got) begin
        m_axi_rvalid = 1;
        m_axi_rdata = rd_val;
        m_axi_rresp = 2'b00;
        ar_got = 0;
      end
      r_fire = m_axi_rvalid && m_axi_rready;
      if (!m_axi_awvalid) begin m_axi_awready = 0; aw_wait = 0; end
      else begin m_axi_awready = aw_wait >= aw_dly; aw_wait++; end
      if (!m_axi_wvalid) begin m_axi_wready = 0; w_wait = 0; end
      else begin m_axi_wready = w_wait >= w_dly; w_wait++; end
      if (!m_axi_arvalid) begin m_axi_arready = 0; ar_wait = 0; end
      else begin m_axi_arready = ar_wait >= ar_dly; ar_wait++; end
      if (m_axi_awvalid && m_axi_awready) begin
        op_log.push_back({1'b1, m_axi_awaddr});
        aw_got = 1;
        last_aw = m_axi_awaddr;
        if (m_axi_awaddr == 32'h4) interrupt_updone = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wdata_wstrb", 64'({m_axi_wdata, m_axi_wstrb}), 64'({32'd1, 4'hF}));
        w_got = 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        op_log.push_back({1'b0, m_axi_araddr});
        ar_got = 1;
      end
      pa = m_axi_awvalid && !m_axi_awready;
      pa_addr = m_axi_awaddr;
      pw = m_axi_wvalid && !m_axi_wready;
      pr = m_axi_arvalid && !m_axi_arready;
      pr_addr = m_axi_araddr;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    start = 0;
    fd_cnt = 0;
    ad_cnt = 0;
    op_log.delete();
  endtask
  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (busy && cyc < budget) begin
      tick();
      cyc++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask
  task automatic pulse_start(input int n);
    n_frames = 16'(n);
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic check_idle(input string p);
    chk({p, "_busy"}, 64'(busy), 0);
    chk({p, "_frame_done"}, 64'(frame_done), 0);
    chk({p, "_all_done"}, 64'(all_done), 0);
    chk({p, "_frame_cnt"}, 64'(frame_cnt), 0);
    chk({p, "_err"}, 64'({err, err_code}), 0);
    chk({p, "_awvalid"}, 64'({m_axi_awvalid, m_axi_wvalid}), 0);
    chk({p, "_bready"}, 64'(m_axi_bready), 0);
    chk({p, "_arvalid"}, 64'(m_axi_arvalid), 0);
    chk({p, "_rready"}, 64'(m_axi_rready), 0);
    chk({p, "_addr"}, 64'({m_axi_awaddr, m_axi_araddr}), 0);
  endtask
  function automatic logic [32:0] exp_op(input int i);
    return i % 3 == 0 ? {1'b1, 32'h0} : i % 3 == 1 ? {1'b0, 32'h8} : {1'b1, 32'h4};
  endfunction
  typedef struct {
    int n; logic [31:0] rdata; int bad_b; int aw_d; int w_d; int ar_d;
    int frames; int err; int code; int alls; int ops;
  } vec_t;
  vec_t vecs[7];
  initial begin
    int cyc;
    vecs[0] = '{2, 32'd129600, -1, 0, 0, 0, 2, 0, 0, 1, 6};
    vecs[1] = '{1, 32'd129600, -1, 3, 7, 5, 1, 0, 0, 1, 3};
    vecs[2] = '{1, 32'd129599, -1, 0, 0, 0, 0, 1, 2, 0, 2};
    vecs[3] = '{1, 32'd129600, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    vecs[4] = '{3, 32'd129600, -1, 7, 0, 2, 3, 0, 0, 1, 9};
    vecs[5] = '{2, 32'd129600, 3, 1, 1, 1, 1, 1, 1, 0, 6};
    vecs[6] = '{0, 32'd129600, -1, 0, 0, 0, 0, 0, 0, 1, 0};
    tick();
    check_idle("reset");
    do_reset();
    check_idle("post_reset");
    foreach (vecs[i]) begin
      do_reset();
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; ar_dly = vecs[i].ar_d;
      rd_val = vecs[i].rdata; bad_b = vecs[i].bad_b; int_never = 0;
      pulse_start(vecs[i].n);
      wait_idle(3000, cyc);
      tick();
      tick();
      chk($sformatf("v%0d_frame_cnt", i), 64'(frame_cnt), 64'(vecs[i].frames));
      chk($sformatf("v%0d_frame_done", i), 64'(fd_cnt), 64'(vecs[i].frames));
      chk($sformatf("v%0d_all_done", i), 64'(ad_cnt), 64'(vecs[i].alls));
      chk($sformatf("v%0d_err", i), 64'({err, err_code}), 64'({vecs[i].err[0], vecs[i].code[1:0]}));
      chk($sformatf("v%0d_busy", i), 64'(busy), 0);
      chk($sformatf("v%0d_ops", i), 64'(op_log.size()), 64'(vecs[i].ops));
      for (int k = 0; k < op_log.size() && k < vecs[i].ops; k++)
        chk($sformatf("v%0d_op%0d", i, k), 64'(op_log[k]), 64'(exp_op(k)));
    end
    // zero frames: all_done exactly one cycle after start, no traffic
    do_reset();
    aw_dly = 0; w_dly = 0; ar_dly = 0; bad_b = -1; rd_val = 32'd129600;
    pulse_start(0);
    chk("zero_all_done", 64'({all_done, busy, m_axi_awvalid, m_axi_arvalid}), 64'(4'b1000));
    tick();
    chk("zero_all_done_end", 64'(all_done), 0);
    chk("zero_no_axi", 64'(op_log.size()), 0);
    // start latency and start ignored while busy
    do_reset();
    pulse_start(1);
    chk("lat_valids", 64'({m_axi_awvalid, m_axi_wvalid, busy}), 64'(3'b111));
    chk("lat_awaddr", 64'(m_axi_awaddr), 0);
    tick();
    tick();
    pulse_start(5);
    wait_idle(500, cyc);
    tick();
    chk("ignore_frame_cnt", 64'(frame_cnt), 1);
    chk("ignore_counts", 64'({fd_cnt[7:0], ad_cnt[7:0]}), 64'(16'h0101));
    chk("ignore_ops", 64'(op_log.size()), 3);
    // asynchronous reset with a write stalled
    do_reset();
    aw_dly = 50;
    pulse_start(1);
    tick();
    tick();
    chk("stall_awvalid", 64'(m_axi_awvalid), 1);
    #2 rst = 1;
    #1 chk("async_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, busy}), 0);
    tick();
    aw_dly = 0;
    // asynchronous reset while waiting for interrupt_updone
    do_reset();
    int_never = 1;
    pulse_start(1);
    repeat (15) tick();
    chk("wait_busy", 64'({busy, m_axi_awvalid, m_axi_arvalid}), 64'(3'b100));
    chk("wait_ops", 64'(op_log.size()), 1);
    #2 rst = 1;
    #1 check_idle("rst_wait");
    tick();
    do_reset();
    pulse_start(1);
`ifdef SEQ_TIMEOUT_EN
    wait_idle(400, cyc);
    chk("tmo_err", 64'({err, err_code}), 64'(3'b111));
    chk("tmo_window", 64'(cyc >= 100 && cyc <= 120), 1);
    chk("tmo_no_all_done", 64'(ad_cnt), 0);
`else
    repeat (400) tick();
    chk("no_tmo_busy", 64'({busy, err, err_code}), 64'(4'b1000));
`endif
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/crf_frame_sequencer.md
Name: crf_frame_sequencer

Overview:
- AXI4-Lite master that sequences the config_register_file / access_control / bicubic datapath across a batch of frames.
- Per frame it:
  - writes UPSTART,
  - waits for interrupt_updone,
  - reads back UPINHSKCNT and checks it against the expected input handshake count,
  - writes UPEND.
- Replaces the host/bench lite master when the upscaler runs standalone, and reports progress and errors.

Parameters:
- AXI_DATA_WIDTH, 32, lite data width.
- AXI_ADDR_WIDTH, 32, lite address width.
- UPSTART_ADDR, 32'h0000_0000, UPSTART register offset.
- UPEND_ADDR, 32'h0000_0004, UPEND register offset.
- UPINHSKCNT_ADDR, 32'h0000_0008, input handshake count register offset.
- EXP_INHSKCNT, 129600, expected UPINHSKCNT per frame (960x540 at 4 px/beat).
- TIMEOUT_CYCLES, 2**24, watchdog limit for WAIT_DONE (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a batch.
- n_frames  in  16  frames in the batch; sampled on the accepted start.
- busy  out  1  high while not IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- all_done  out  1  one-cycle pulse when the batch completes without error.
- frame_cnt  out  16  frames completed in the current batch.
- err  out  1  sticky error; cleared on the next accepted start.
- err_code  out  2  01 = bad bresp/rresp, 10 = count mismatch, 11 = timeout.
- interrupt_updone  in  1  level from the CRF.
- m_axi_awvalid out 1; m_axi_awaddr out AXI_ADDR_WIDTH; m_axi_awprot out 3; m_axi_awready in 1.
- m_axi_wvalid out 1; m_axi_wdata out AXI_DATA_WIDTH; m_axi_wstrb out AXI_DATA_WIDTH/8; m_axi_wready in 1.
- m_axi_bvalid in 1; m_axi_bresp in 2; m_axi_bready out 1.
- m_axi_arvalid out 1; m_axi_araddr out AXI_ADDR_WIDTH; m_axi_arprot out 3; m_axi_arready in 1.
- m_axi_rvalid in 1; m_axi_rdata in AXI_DATA_WIDTH; m_axi_rresp in 2; m_axi_rready out 1.

Behaviour:
- Reset values: all outputs 0 and FSM in IDLE.
- Constant outputs: awprot = arprot = 0; wstrb = all ones; wdata = 1 for both register writes.
- FSM states: IDLE, WR_START, B_START, WAIT_DONE, RD_ADDR, RD_DATA, WR_END, B_END, NEXT.
- IDLE:
  - start → latch n_frames, clear frame_cnt/err/err_code.
  - n_frames == 0 → all_done pulse the next cycle, no AXI traffic, stay IDLE.
  - Otherwise → WR_START.
  - start while busy is ignored.
- WR_START / WR_END:
  - awvalid and wvalid rise in the same cycle.
  - Each drops independently on its own handshake; a per-channel done flag records it.
  - Move to B_* once both channels have handshaken. Simultaneous handshakes are legal.
- B_*:
  - bready = 1.
  - On bvalid: bresp != 0 → err = 1, err_code = 01, go to IDLE (no all_done).
  - Otherwise B_START → WAIT_DONE, B_END → NEXT.
- WAIT_DONE:
  - Advances to RD_ADDR on interrupt_updone == 1 (level); the CRF clears it on the UPEND write.
- RD_ADDR / RD_DATA:
  - RD_ADDR: arvalid with araddr = UPINHSKCNT_ADDR, held until arready.
  - RD_DATA: rready = 1.
  - On rvalid: rresp != 0 → error 01; rdata != EXP_INHSKCNT → err = 1, err_code = 10, IDLE; else WR_END.
- NEXT:
  - frame_cnt++ and frame_done pulse.
  - If frame_cnt+1 == n_frames → all_done pulse and IDLE; else WR_START.
- AXI rules:
  - A valid is never dropped before its ready.
  - Valids never depend combinationally on readies.
  - At most one transaction is outstanding.
  - All outputs come from registers.
- Latency: start → awvalid is 1 cycle.
- Reset mid-transaction: all valids drop immediately and the FSM returns to IDLE.
- frame_cnt is 16 bits; it cannot wrap because n_frames ≤ 65535.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A 25-bit watchdog counts cycles in WAIT_DONE and clears on leaving the state.
  - Reaching TIMEOUT_CYCLES → err = 1, err_code = 11, IDLE.
- Undefined: no counter; WAIT_DONE waits indefinitely; code 11 is never produced.

Decomposition:
- Package crf_seq_pkg:
  - FSM state enum (typedef seq_state_e).
  - err_code localparams.
  - Default register offsets.
- Sub-module: one natural sub-module, axil_wr_channel. It holds the AW/W valid-hold and done-flag logic, is instanced once, and is reused for both UPSTART and UPEND.
- Read path: stays inline in the sequencer.

Test Plan:
- Nominal frames: n_frames = 2; responder always ready with OKAY; rdata = 129600; interrupt 20 cycles after each B → two frame_done pulses, all_done, frame_cnt = 2, err = 0, four writes and two reads in order START, CNT, END.
- Backpressure: awready delayed 3 cycles, wready delayed 7, arready delayed 5 → valids stay high until handshake, addresses and data stay stable, the frame still completes.
- Count mismatch: rdata = 129599 → err = 1, err_code = 10, no UPEND write, no all_done, busy = 0.
- Bad response and zero frames:
  - bresp = 2'b10 on the UPSTART write → error 01, abort.
  - Separately, n_frames = 0 → all_done the cycle after start with no AXI activity.
- Reset and start handling:
  - rst asserted during WAIT_DONE → all outputs 0 asynchronously.
  - start pulsed while busy → ignored.
  - With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 100: interrupt never arrives → err_code = 11 after 100 cycles.
